control_padding_reader: RTL

Reads a zero-padded feature map, previously written into the shared 128-bit line buffer by the padding writer, back out as a 128-bit word stream for the next convolution stage. Walks the padded map row by row from the base word address. Reads are gated by row-availability credits from the writer and by a ready/valid backpressure handshake to the consumer. Sits between the padding buffer's read port and the next layer's PE-array input.

---
 rtl/control_padding_reader_if.sv | 30 +++
 rtl/control_padding_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/control_padding_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : control_padding_reader_if
// Description : Buffer read port plus output word stream of the padding reader
// Revision    : 1.0 - initial release
// ============================================================================
interface control_padding_reader_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in;
    logic              row_last;
    logic              map_last;

    modport master (
        output rd_en, rd_addr, data_out, valid_out, row_last, map_last,
        input  rd_data, ready_in
    );

    modport slave (
        input  rd_en, rd_addr, data_out, valid_out, row_last, map_last,
        output rd_data, ready_in
    );
endinterface
`default_nettype wire

// File: rtl/control_padding_reader.sv
`default_nettype none
// ============================================================================
// Module      : control_padding_reader
// Description : Streams a zero-padded map out of the line buffer, gated by
//               writer row credits and consumer backpressure
// Revision    : 1.0 - initial release
// ============================================================================
module control_padding_reader #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] IFM_C,
    input  logic [10:0] IFM_W,
    input  logic        padding,
    input  logic [31:0] base_addr,
    input  logic        row_avail,
    output logic        busy,
    output logic        done,
    control_padding_reader_if.master bus
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WAIT_ROW = 3'd1;
    localparam logic [2:0] c_READ_ROW = 3'd2;
    localparam logic [2:0] c_DRAIN    = 3'd3;
    localparam logic [2:0] c_FINISH   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;

    logic [31:0]       r_wpr;
    logic [11:0]       r_h;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_word;
    logic [11:0]       r_row;
    logic [11:0]       r_credits;

    logic              r_pend;
    logic              r_pend_rl;
    logic              r_pend_ml;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_rl;
    logic [1:0]        r_fifo_ml;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic [11:0]       w_h;
    logic [31:0]       w_wpr;
    logic              w_start;
    logic              w_valid;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_row_end;
    logic              w_map_end;

    assign w_h       = {1'b0, IFM_W} + (padding ? 12'd2 : 12'd0);
    assign w_wpr     = (32'(IFM_C) * 32'(w_h)) >> 4;
    assign w_start   = start && (r_state == c_IDLE);
    assign w_valid   = (r_count != 2'd0);
    assign w_pop     = w_valid && bus.ready_in;
    // Occupancy counts the word whose read data lands this cycle, so the
    // two-entry FIFO can never be oversubscribed.
    assign w_occ     = {1'b0, r_count} + {2'b00, r_pend};
    assign w_issue   = (r_state == c_READ_ROW) &&
                       ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));
    assign w_row_end = (r_word == r_wpr - 32'd1);
    assign w_map_end = w_row_end && (r_row == r_h - 12'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = (w_wpr == 32'd0) ? c_FINISH : c_WAIT_ROW;
                end
            end
            c_WAIT_ROW: begin
                if (r_credits > r_row) begin
                    w_next_state = c_READ_ROW;
                end
            end
            c_READ_ROW: begin
                if (w_issue && w_row_end) begin
                    w_next_state = w_map_end ? c_DRAIN : c_WAIT_ROW;
                end
            end
            c_DRAIN: begin
                if ((r_count == 2'd0) && !r_pend) begin
                    w_next_state = c_FINISH;
                end
            end
            c_FINISH: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (r_state != c_IDLE);
        done      = (r_state == c_FINISH);
        bus.rd_en = w_issue;
    end

    // Map walk, credits and read-data FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wpr     <= '0;
            r_h       <= '0;
            r_addr    <= '0;
            r_word    <= '0;
            r_row     <= '0;
            r_credits <= '0;
            r_pend    <= 1'b0;
            r_pend_rl <= 1'b0;
            r_pend_ml <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_rl <= '0;
            r_fifo_ml <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_start) begin
                r_wpr     <= w_wpr;
                r_h       <= w_h;
                r_addr    <= ADDR_W'(base_addr >> 4);
                r_word    <= '0;
                r_row     <= '0;
                r_credits <= {11'd0, row_avail};
            end else if ((r_state != c_IDLE) && row_avail && (r_credits < r_h)) begin
                r_credits <= r_credits + 12'd1;
            end

            if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (w_row_end) begin
                    r_word <= '0;
                    r_row  <= r_row + 12'd1;
                end else begin
                    r_word <= r_word + 32'd1;
                end
            end

            // Tags are fixed at issue and ride alongside the returning data
            r_pend    <= w_issue;
            r_pend_rl <= w_issue && w_row_end;
            r_pend_ml <= w_issue && w_map_end;

            if (r_pend) begin
                r_fifo_data[r_wptr] <= bus.rd_data;
                r_fifo_rl[r_wptr]   <= r_pend_rl;
                r_fifo_ml[r_wptr]   <= r_pend_ml;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

    assign bus.rd_addr   = r_addr;
    assign bus.data_out  = r_fifo_data[r_rptr];
    assign bus.valid_out = w_valid;
    assign bus.row_last  = w_valid && r_fifo_rl[r_rptr];
    assign bus.map_last  = w_valid && r_fifo_ml[r_rptr];

endmodule
`default_nettype wire
